// File: rtl/io_port_bank_pkg.sv
// Shared defaults and helpers for the processor I/O port bank.
package io_port_bank_pkg;

    localparam int NUIOIN_DEF = 4;   // input ports
    localparam int NUIOOU_DEF = 4;   // output ports
    localparam int NBIN_DEF   = 19;  // io_in word width
    localparam int NBOUT_DEF  = 28;  // io_out word width
    localparam int FDEPTH_DEF = 4;   // entries per FIFO

    // Index of the lowest set bit in a strobe vector, -1 when none is set.
    // Both strobe decoders use it so multi-hot strobes resolve identically.
    function automatic int lowest_idx(input logic [31:0] v);
        int idx;
        idx = -1;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/io_port_bank_fifo.sv
// Show-ahead synchronous FIFO; the head word is visible on dout while not empty.
module io_fifo
    import io_port_bank_pkg::*;
#(
    parameter int W     = NBIN_DEF,
    parameter int DEPTH = FDEPTH_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    // Accept/advance decisions; a full FIFO still accepts when it pops in the same cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        empty    = (count_q == '0);
        full     = (count_q == CW'(DEPTH));
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        dout     = empty ? '0 : mem_q[rd_ptr_q];
    end

    // Pointer and occupancy registers; power-of-two depth makes pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Word storage.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; dout is forced to zero while empty, so stale words never leak.
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/io_port_bank.sv
// Host-side responder for processor I/O strobes: input FIFOs feed io_in, output FIFOs capture io_out.
module io_port_bank
    import io_port_bank_pkg::*;
#(
    parameter int NUIOIN = NUIOIN_DEF,
    parameter int NUIOOU = NUIOOU_DEF,
    parameter int NBIN   = NBIN_DEF,
    parameter int NBOUT  = NBOUT_DEF,
    parameter int FDEPTH = FDEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUIOIN*NBIN-1:0]   src_data,
    input  logic [NUIOIN-1:0]        src_valid,
    output logic [NUIOIN-1:0]        src_ready,
    input  logic [NUIOIN-1:0]        req_in,
    output logic [NBIN-1:0]          io_in,
    input  logic [NUIOOU-1:0]        out_en,
    input  logic [NBOUT-1:0]         io_out,
    output logic [NUIOOU*NBOUT-1:0]  snk_data,
    output logic [NUIOOU-1:0]        snk_valid,
    input  logic [NUIOOU-1:0]        snk_ready,
    output logic [NUIOIN-1:0]        underflow,
    output logic [NUIOOU-1:0]        overflow
);

    logic [NUIOIN-1:0] in_full, in_empty, in_push, in_pop, rd_sel;
    logic [NUIOOU-1:0] out_full, out_empty, out_push, out_pop, wr_sel;
    logic [NBIN-1:0]   in_head [NUIOIN];
    logic [NUIOIN-1:0] underflow_q, underflow_d;
    logic [NUIOOU-1:0] overflow_q, overflow_d;

    for (genvar k = 0; k < NUIOIN; k++) begin : g_in
        io_fifo #(.W(NBIN), .DEPTH(FDEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (in_push[k]),
            .din   (src_data[k*NBIN +: NBIN]),
            .pop   (in_pop[k]),
            .dout  (in_head[k]),
            .full  (in_full[k]),
            .empty (in_empty[k])
        );
    end

    for (genvar k = 0; k < NUIOOU; k++) begin : g_out
        io_fifo #(.W(NBOUT), .DEPTH(FDEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (out_push[k]),
            .din   (io_out),
            .pop   (out_pop[k]),
            .dout  (snk_data[k*NBOUT +: NBOUT]),
            .full  (out_full[k]),
            .empty (out_empty[k])
        );
    end

    // Strobe priority, zero-latency read mux, FIFO handshakes and sticky flag updates.
    always_comb begin
        int rd_idx;
        int wr_idx;
        rd_idx = lowest_idx(32'(req_in));
        wr_idx = lowest_idx(32'(out_en));
        rd_sel = '0;
        wr_sel = '0;
        io_in  = '0;
        for (int k = 0; k < NUIOIN; k++) rd_sel[k] = (rd_idx == k);
        for (int k = 0; k < NUIOOU; k++) wr_sel[k] = (wr_idx == k);
        // An empty FIFO presents a zero head, so an empty strobe reads 0 without bypass.
        for (int k = 0; k < NUIOIN; k++) begin
            if (rd_sel[k]) io_in = in_head[k];
        end
        in_push     = src_valid & ~in_full;
        in_pop      = rd_sel & ~in_empty;
        out_push    = wr_sel;
        out_pop     = snk_ready & ~out_empty;
        underflow_d = underflow_q | (rd_sel & in_empty);
        overflow_d  = overflow_q | (wr_sel & out_full & ~snk_ready);
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underflow_q <= '0;
            overflow_q  <= '0;
        end else begin
            underflow_q <= underflow_d;
            overflow_q  <= overflow_d;
        end
    end

    assign src_ready = ~in_full;
    assign snk_valid = ~out_empty;
    assign underflow = underflow_q;
    assign overflow  = overflow_q;

endmodule
